react_ctrl: RTL and testbench

Trial sequencer for the reaction-time tester. On a start press it waits a pseudo-random delay, lights the stimulus LED, and counts elapsed milliseconds in 4-digit BCD until the react button is pressed. It then presents the result on `dat`, which feeds the 4-digit seven-segment display driver directly. A react press during the random wait is flagged as a false start.

---
 rtl/react_ctrl.sv | 161 ++++++++++++++++
 tb/tb_react_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/react_ctrl.sv
// Reaction-time trial sequencer: random wait, stimulus LED, BCD millisecond
// count until react, with false-start detection.
module react_ctrl #(
    parameter int TICK_DIV    = 100000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        react,
    output logic        led,
    output logic [15:0] dat,
    output logic        done,
    output logic        err
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS)) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MEASURE,
        S_SHOW,
        S_FOUL
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, react_q;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               led_q, led_d;
    logic [15:0]        dat_q, dat_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               start_e, react_e, tick, enter_wait;

    assign led  = led_q;
    assign dat  = dat_q;
    assign done = done_q;
    assign err  = err_q;

    // Decimal increment that ripples the carry digit by digit.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        start_e    = start & ~start_q;
        react_e    = react & ~react_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tick       = (div_q == DIV_W'(TICK_DIV - 1));
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        led_d      = led_q;
        dat_d      = dat_q;
        done_d     = done_q;
        err_d      = err_q;
        enter_wait = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_e) enter_wait = 1'b1;
            end
            S_WAIT: begin
                // A react edge beats an expiry tick landing in the same cycle.
                if (react_e) begin
                    state_d = S_FOUL;
                    err_d   = 1'b1;
                    dat_d   = 16'hFFFF;
                end else if (tick) begin
                    if (wait_cnt_q == WAIT_W'(1)) begin
                        state_d = S_MEASURE;
                        led_d   = 1'b1;
                        dat_d   = 16'h0000;
                        div_d   = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    end
                end
            end
            S_MEASURE: begin
                if (react_e) begin
                    state_d = S_SHOW;
                    led_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if (dat_q == 16'h9999) begin
                        state_d = S_SHOW;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        dat_d = bcd_inc(dat_q);
                    end
                end
            end
            S_SHOW, S_FOUL: begin
                if (start_e) enter_wait = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_wait) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q[RAND_BITS-1:0]);
            div_d      = '0;
            led_d      = 1'b0;
            dat_d      = 16'h0000;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    // Button history resets high so a button held through reset gives no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b1;
            react_q    <= 1'b1;
            lfsr_q     <= 16'hACE1;
            div_q      <= '0;
            wait_cnt_q <= '0;
            led_q      <= 1'b0;
            dat_q      <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            react_q    <= react;
            lfsr_q     <= lfsr_d;
            div_q      <= div_d;
            wait_cnt_q <= wait_cnt_d;
            led_q      <= led_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_react_ctrl.sv
// Self-checking bench for react_ctrl: a cycle-level behavioural model of the
// trial timeline, checked every cycle, plus directed literal expectations.
module tb_react_ctrl;

    localparam int TD = 4;
    localparam int MW = 2;
    localparam int RB = 2;

    localparam int P_IDLE = 0, P_WAIT = 1, P_MEAS = 2, P_SHOW = 3, P_FOUL = 4;

    logic        clk = 1'b0;
    logic        rst, start, react;
    logic        led, done, err;
    logic [15:0] dat;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase, cycles elapsed in phase, chosen wait in ms.
    int          m_phase;
    int          m_elapsed;
    int          m_wait_ms;
    logic [15:0] m_lfsr;
    logic        m_sp, m_rp;
    logic        m_led, m_done, m_err;
    logic [15:0] m_dat;

    logic [15:0] prev_dat;
    logic [2:0]  seen_carry = 3'b000;

    react_ctrl #(.TICK_DIV(TD), .MIN_WAIT_MS(MW), .RAND_BITS(RB)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .react(react),
        .led  (led),
        .dat  (dat),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        return 16'(((n / 1000) % 10) << 12 | ((n / 100) % 10) << 8 |
                   ((n / 10) % 10) << 4 | (n % 10));
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic enter_wait_model();
        m_phase   = P_WAIT;
        m_elapsed = 0;
        m_wait_ms = MW + int'(m_lfsr) % (1 << RB);
        m_led     = 1'b0;
        m_dat     = 16'h0000;
        m_done    = 1'b0;
        m_err     = 1'b0;
    endtask

    // Model and compare on the falling edge, mirroring the preceding rising edge.
    always @(negedge clk) begin
        logic se, re;
        if (rst) begin
            m_phase = P_IDLE; m_elapsed = 0; m_lfsr = 16'hACE1;
            m_sp = 1'b1; m_rp = 1'b1;
            m_led = 1'b0; m_dat = 16'h0000; m_done = 1'b0; m_err = 1'b0;
        end else begin
            se = start & ~m_sp;
            re = react & ~m_rp;
            case (m_phase)
                P_IDLE: if (se) enter_wait_model();
                P_WAIT: begin
                    if (re) begin
                        m_phase = P_FOUL; m_err = 1'b1; m_dat = 16'hFFFF;
                    end else if (m_elapsed + 1 == m_wait_ms * TD) begin
                        m_phase = P_MEAS; m_elapsed = 0; m_led = 1'b1; m_dat = 16'h0000;
                    end else begin
                        m_elapsed++;
                    end
                end
                P_MEAS: begin
                    if (re) begin
                        m_phase = P_SHOW; m_led = 1'b0; m_done = 1'b1;
                        m_dat = to_bcd(m_elapsed / TD);
                    end else if ((m_elapsed + 1) / TD == 10000) begin
                        m_phase = P_SHOW; m_led = 1'b0; m_done = 1'b1; m_dat = 16'h9999;
                    end else begin
                        m_elapsed++;
                        m_dat = to_bcd(m_elapsed / TD);
                    end
                end
                default: if (se) enter_wait_model();
            endcase
            m_lfsr = lfsr_next(m_lfsr);
            m_sp   = start;
            m_rp   = react;
        end
        check("led", 32'(led), 32'(m_led));
        check("dat", 32'(dat), 32'(m_dat));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        if (prev_dat == 16'h0009 && dat == 16'h0010) seen_carry[0] = 1'b1;
        if (prev_dat == 16'h0099 && dat == 16'h0100) seen_carry[1] = 1'b1;
        if (prev_dat == 16'h0999 && dat == 16'h1000) seen_carry[2] = 1'b1;
        prev_dat = dat;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic press_react();
        react = 1'b1; step(1); react = 1'b0;
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (!led && n < 4 * (MW + (1 << RB)) + 20) begin
            step(1);
            n++;
        end
        check("led_rise_timeout", 32'(led), 32'd1);
    endtask

    initial begin
        int n, w, d;
        rst = 1'b1; start = 1'b1; react = 1'b1;
        step(3);
        check("rst_led", 32'(led), 32'd0);
        check("rst_dat", 32'(dat), 32'h0000);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step(5);
        check("held_dat", 32'(dat), 32'h0000);
        check("held_done_err", {30'd0, done, err}, 32'd0);
        start = 1'b0; react = 1'b0;
        step(2);

        // Normal trial: 37 ms reaction.
        pulse_start();
        w = m_wait_ms;
        check("wait_range", 32'(w >= MW && w < MW + (1 << RB)), 32'd1);
        wait_led(n);
        check("led_latency", 32'(n), 32'(TD * w));
        step(149);
        press_react();
        check("trial_dat", 32'(dat), 32'h0037);
        check("trial_done", 32'(done), 32'd1);
        check("trial_led", 32'(led), 32'd0);
        step(3);

        // False start, then a clean restart.
        pulse_start();
        step(3);
        press_react();
        check("foul_err", 32'(err), 32'd1);
        check("foul_dat", 32'(dat), 32'hFFFF);
        check("foul_led", 32'(led), 32'd0);
        step(2);
        pulse_start();
        check("restart_err", 32'(err), 32'd0);
        check("restart_dat", 32'(dat), 32'h0000);

        // React on a tick cycle keeps the pre-tick count.
        wait_led(n);
        step(4 * 5 - 1);
        press_react();
        check("coincide_dat", 32'(dat), 32'h0004);
        step(2);

        // React on the expiry tick of the wait.
        pulse_start();
        w = m_wait_ms;
        step(TD * w - 1);
        press_react();
        check("expiry_err", 32'(err), 32'd1);
        check("expiry_led", 32'(led), 32'd0);
        step(2);

        // Starts during MEASURE are ignored; reset mid-MEASURE clears all.
        pulse_start();
        wait_led(n);
        step(10);
        pulse_start();
        step(5);
        pulse_start();
        check("ignored_start_dat", 32'(dat), 32'h0004);
        rst = 1'b1;
        step(1);
        check("midrst_all", {14'd0, led, done, err, dat}, 32'd0);
        rst = 1'b0;
        step(3);

        // Randomised trials, including random false starts and stray starts.
        for (int t = 0; t < 10; t++) begin
            pulse_start();
            w = m_wait_ms;
            if ($urandom_range(3, 0) == 0) begin
                step($urandom_range(TD * w - 2, 0));
                press_react();
            end else begin
                wait_led(n);
                d = $urandom_range(300, 0);
                for (int k = 0; k < d; k++) begin
                    start = ($urandom_range(15, 0) == 0);
                    step(1);
                end
                start = 1'b0;
                press_react();
            end
            step($urandom_range(5, 1));
        end

        // Run to saturation with no react.
        pulse_start();
        wait_led(n);
        n = 0;
        while (!done && n < 10000 * TD + 50) begin
            step(1);
            n++;
        end
        check("sat_done", 32'(done), 32'd1);
        check("sat_dat", 32'(dat), 32'h9999);
        check("sat_led", 32'(led), 32'd0);
        check("sat_cycles", 32'(n), 32'(10000 * TD));
        check("carry_seen", 32'(seen_carry), 32'b111);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
